// File: rtl/seq_mul_div_unit_if.sv
// Handshake and result bundle between a requester and the iterative multiply/divide unit.
// The requester drives start/op/operands; the unit returns status and the HI/LO results.
interface seq_mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/seq_mul_div_unit.sv
// Iterative signed/unsigned multiply and divide producing HI/LO.
// Shift-add multiply and restoring divide run on magnitudes; the FIX state restores the signs.
module seq_mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                clr,
  seq_mul_div_unit_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   iter;
  logic               done_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   opd;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH:0]     rem;

  logic               op_signed;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // opd is the multiplicand for MUL and the divisor for DIV; quot starts as the
  // multiplier (shifted out LSB first) or the dividend (shifted out MSB first).
  always_comb begin
    op_signed = ~bus.op[0];
    mul_sum   = {1'b0, rem[WIDTH-1:0]} + (quot[0] ? {1'b0, opd} : '0);
    div_shift = {rem, quot[WIDTH-1]};
    div_diff  = div_shift - {2'b00, opd};
    prod      = neg_2w({rem[WIDTH-1:0], quot}, neg_q);
    fix_hi    = is_div ? neg_w(rem[WIDTH-1:0], neg_r) : prod[2*WIDTH-1:WIDTH];
    fix_lo    = is_div ? neg_w(quot, neg_q)           : prod[WIDTH-1:0];
  end

  // Control and result registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= IDLE;
      iter   <= '0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            iter  <= '0;
            dbz_r <= 1'b0;
            if (bus.op[1] && bus.b == '0) begin
              hi_r   <= bus.a;
              lo_r   <= '1;
              dbz_r  <= 1'b1;
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          iter <= iter + 1'b1;
          if (iter == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          hi_r   <= fix_hi;
          lo_r   <= fix_lo;
          done_r <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Iteration datapath; contents are only meaningful between acceptance and FIX
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      is_div <= bus.op[1];
      neg_q  <= op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      neg_r  <= op_signed & bus.a[WIDTH-1];
      rem    <= '0;
      opd    <= bus.op[1] ? magnitude(bus.b, op_signed) : magnitude(bus.a, op_signed);
      quot   <= bus.op[1] ? magnitude(bus.a, op_signed) : magnitude(bus.b, op_signed);
    end else if (state == CALC) begin
      if (is_div) begin
        rem  <= div_diff[WIDTH+1] ? div_shift[WIDTH:0] : div_diff[WIDTH:0];
        quot <= {quot[WIDTH-2:0], ~div_diff[WIDTH+1]};
      end else begin
        rem  <= {1'b0, mul_sum[WIDTH:1]};
        quot <= {mul_sum[0], quot[WIDTH-1:1]};
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_r;

endmodule
